move_tick_sched: RTL and testbench

Multi-channel movement-tick scheduler for the game datapath. It generates independent, run-time-programmable tick rates for up to NUM_CH game objects (player, enemies, projectiles). It arbitrates the resulting ticks round-robin onto the single shared position-update datapath through a valid/ready handshake. It replaces per-object fixed-frequency dividers, so every object's speed is set by a register write instead of a rebuild.

---
 rtl/move_sched_pkg.sv | 24 ++
 rtl/move_rr_pick.sv | 35 +++
 rtl/move_tick_sched.sv | 150 +++++++++++++++
 tb/tb_move_tick_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_sched_pkg.sv
// ============================================================================
//  Module   : move_sched_pkg
//  Purpose  : Shared types, constants and helpers for the movement-tick scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package move_sched_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } arb_state_e;

   localparam int MISS_W = 8;

   // Periods below 2 cannot produce a wrap-then-count cycle, so they are clamped.
   function automatic logic [31:0] eff_period(input logic [31:0] per);
      return (per < 32'd2) ? 32'd2 : per;
   endfunction

endpackage

`default_nettype wire

// File: rtl/move_rr_pick.sv
// ============================================================================
//  Module   : move_rr_pick
//  Purpose  : Combinational round-robin picker: first request after last_i, wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [IDX_W-1:0] grant_o,
   output logic             found_o
);

   always_comb begin
      logic [IDX_W-1:0] idx;
      idx     = '0;
      grant_o = '0;
      found_o = 1'b0;
      // Scan farthest-first so the closest request after last_i is written last.
      for (int k = N; k >= 1; k--) begin
         idx = IDX_W'((int'(last_i) + k) % N);
         if (req_i[idx]) begin
            grant_o = idx;
            found_o = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/move_tick_sched.sv
// ============================================================================
//  Module   : move_tick_sched
//  Purpose  : Per-channel programmable tick generators arbitrated round-robin
//             onto one valid/ready update port. Optional MOVE_SCHED_MISS_CNT_EN
//             adds saturating per-channel missed-tick counters on miss_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_tick_sched
   import move_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CLK_HZ = 100000000,
   parameter int DEF_HZ = 10,
   parameter int PER_W  = 27
) (
   input  logic                      Clk_In,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic                      cfg_we,
   input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
   input  logic [PER_W-1:0]          cfg_period,
   output logic                      upd_valid,
   output logic [$clog2(NUM_CH)-1:0] upd_ch,
   input  logic                      upd_ready,
   output logic [NUM_CH-1:0]         pend
`ifdef MOVE_SCHED_MISS_CNT_EN
   ,
   output logic [MISS_W*NUM_CH-1:0]  miss_cnt
`endif
);

   localparam int               c_IDX_W   = $clog2(NUM_CH);
   localparam logic [PER_W-1:0] c_DEF_PER = PER_W'(CLK_HZ / DEF_HZ);

   arb_state_e           state_q, state_d;
   logic [c_IDX_W-1:0]   upd_ch_q, upd_ch_d;
   logic [c_IDX_W-1:0]   last_q, last_d;
   logic [NUM_CH-1:0]    pend_q, pend_d;
   logic [NUM_CH-1:0]    w_wr_hit, w_expire, w_clr;
   logic [c_IDX_W-1:0]   w_pick;
   logic                 w_found;
   logic                 w_hs;

   assign w_hs = (state_q == ST_OFFER) && upd_ready;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [PER_W-1:0] cnt_q, period_q;

      assign w_wr_hit[i] = cfg_we && (cfg_ch == c_IDX_W'(i));
      // A period write restarts the count, so it suppresses an expiry in the same cycle.
      assign w_expire[i] = ch_en[i] && !w_wr_hit[i] &&
                           (32'(cnt_q) >= eff_period(32'(period_q)) - 32'd1);
      assign w_clr[i]    = w_hs && (upd_ch_q == c_IDX_W'(i));

      always_ff @(posedge Clk_In) begin
         if (rst) begin
            cnt_q    <= '0;
            period_q <= c_DEF_PER;
         end else if (w_wr_hit[i]) begin
            cnt_q    <= '0;
            period_q <= cfg_period;
         end else if (!ch_en[i] || w_expire[i]) begin
            cnt_q    <= '0;
         end else begin
            cnt_q    <= cnt_q + PER_W'(1);
         end
      end

`ifdef MOVE_SCHED_MISS_CNT_EN
      logic [MISS_W-1:0] miss_q;

      always_ff @(posedge Clk_In) begin
         if (rst || w_wr_hit[i]) begin
            miss_q <= '0;
         end else if (w_expire[i] && pend_q[i] && !w_clr[i] && (miss_q != '1)) begin
            miss_q <= miss_q + MISS_W'(1);
         end
      end

      assign miss_cnt[MISS_W*i +: MISS_W] = miss_q;
`endif
   end

   // A fresh expiry wins over the handshake clear: that is a new tick, not a loss.
   always_comb begin
      pend_d = pend_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!ch_en[i]) begin
            pend_d[i] = 1'b0;
         end else if (w_expire[i]) begin
            pend_d[i] = 1'b1;
         end else if (w_clr[i]) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   move_rr_pick #(
      .N       (NUM_CH)
   ) u_pick (
      .req_i   (pend_q),
      .last_i  (last_q),
      .grant_o (w_pick),
      .found_o (w_found)
   );

   always_comb begin
      state_d  = state_q;
      upd_ch_d = upd_ch_q;
      last_d   = last_q;
      case (state_q)
         ST_IDLE: begin
            if (w_found) begin
               state_d  = ST_OFFER;
               upd_ch_d = w_pick;
            end
         end
         ST_OFFER: begin
            if (upd_ready) begin
               state_d = ST_IDLE;
               last_d  = upd_ch_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk_In) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         upd_ch_q <= '0;
         last_q   <= c_IDX_W'(NUM_CH - 1);
         pend_q   <= '0;
      end else begin
         state_q  <= state_d;
         upd_ch_q <= upd_ch_d;
         last_q   <= last_d;
         pend_q   <= pend_d;
      end
   end

   assign upd_valid = (state_q == ST_OFFER);
   assign upd_ch    = upd_ch_q;
   assign pend      = pend_q;

endmodule

`default_nettype wire

// File: tb/tb_move_tick_sched.sv
// ============================================================================
//  Module   : tb_move_tick_sched
//  Purpose  : Directed scenarios plus randomized traffic against a countdown model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_move_tick_sched;

   localparam int NUM_CH = 4;
   localparam int CLK_HZ = 100;
   localparam int DEF_HZ = 10;
   localparam int PER_W  = 27;

   logic              Clk_In = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] ch_en = '0;
   logic              cfg_we = 1'b0;
   logic [1:0]        cfg_ch = '0;
   logic [PER_W-1:0]  cfg_period = '0;
   logic              upd_valid;
   logic [1:0]        upd_ch;
   logic              upd_ready = 1'b0;
   logic [NUM_CH-1:0] pend;
`ifdef MOVE_SCHED_MISS_CNT_EN
   logic [8*NUM_CH-1:0] miss_cnt;
`endif

   move_tick_sched #(
      .NUM_CH (NUM_CH),
      .CLK_HZ (CLK_HZ),
      .DEF_HZ (DEF_HZ),
      .PER_W  (PER_W)
   ) dut (
      .Clk_In     (Clk_In),
      .rst        (rst),
      .ch_en      (ch_en),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .upd_valid  (upd_valid),
      .upd_ch     (upd_ch),
      .upd_ready  (upd_ready),
      .pend       (pend)
`ifdef MOVE_SCHED_MISS_CNT_EN
      ,
      .miss_cnt   (miss_cnt)
`endif
   );

   always #5 Clk_In = ~Clk_In;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: each channel counts down the cycles left until its next tick.
   int m_rem  [NUM_CH];
   int m_per  [NUM_CH];
   int m_miss [NUM_CH];
   bit m_pend [NUM_CH];
   bit m_valid;
   int m_ch;
   int m_last;

   int cyc = 0;
   bit prev_valid = 1'b0;
   int rise_q[$];
   int acc_cyc[$];
   int acc_ch[$];

   function automatic int eff(input int p);
      return (p < 2) ? 2 : p;
   endfunction

   function automatic int rise_at(input int k);
      return (k < rise_q.size()) ? rise_q[k] : -1;
   endfunction

   function automatic int acc_cyc_at(input int k);
      return (k < acc_cyc.size()) ? acc_cyc[k] : -1;
   endfunction

   function automatic int acc_ch_at(input int k);
      return (k < acc_ch.size()) ? acc_ch[k] : -1;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_per[i]  = CLK_HZ / DEF_HZ;
         m_rem[i]  = eff(m_per[i]);
         m_miss[i] = 0;
         m_pend[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_ch    = 0;
      m_last  = NUM_CH - 1;
   endtask

   task automatic model_update();
      bit tick [NUM_CH];
      bit clr  [NUM_CH];
      bit hs;
      if (rst) begin
         model_reset();
         return;
      end
      hs = m_valid && upd_ready;
      for (int i = 0; i < NUM_CH; i++) begin
         clr[i]  = hs && (m_ch == i);
         tick[i] = 1'b0;
         if (cfg_we && (int'(cfg_ch) == i)) begin
            m_per[i]  = int'(cfg_period);
            m_rem[i]  = eff(m_per[i]);
            m_miss[i] = 0;
         end else if (!ch_en[i]) begin
            m_rem[i] = eff(m_per[i]);
         end else begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin
               tick[i]  = 1'b1;
               m_rem[i] = eff(m_per[i]);
            end
         end
      end
      if (m_valid) begin
         if (hs) begin
            m_last  = m_ch;
            m_valid = 1'b0;
         end
      end else begin
         for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (m_last + k) % NUM_CH;
            if (m_pend[c]) begin
               m_ch    = c;
               m_valid = 1'b1;
               break;
            end
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (tick[i] && m_pend[i] && !clr[i] && m_miss[i] < 255) m_miss[i]++;
         if (!ch_en[i])    m_pend[i] = 1'b0;
         else if (tick[i]) m_pend[i] = 1'b1;
         else if (clr[i])  m_pend[i] = 1'b0;
      end
   endtask

   task automatic compare_all();
      logic [NUM_CH-1:0] ep;
      for (int i = 0; i < NUM_CH; i++) ep[i] = m_pend[i];
      check_eq("upd_valid", upd_valid, m_valid);
      check_eq("upd_ch", upd_ch, m_ch);
      check_eq("pend", pend, ep);
`ifdef MOVE_SCHED_MISS_CNT_EN
      for (int i = 0; i < NUM_CH; i++)
         check_eq($sformatf("miss_cnt[%0d]", i), miss_cnt[8*i +: 8], m_miss[i]);
`endif
   endtask

   task automatic step();
      if (upd_valid === 1'b1 && upd_ready) begin
         acc_cyc.push_back(cyc + 1);
         acc_ch.push_back(int'(upd_ch));
      end
      @(posedge Clk_In);
      cyc++;
      model_update();
      #1;
      compare_all();
      if (upd_valid === 1'b1 && !prev_valid) rise_q.push_back(cyc);
      prev_valid = (upd_valid === 1'b1);
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      ch_en     = '0;
      cfg_we    = 1'b0;
      upd_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      cyc = 0;
      rise_q.delete();
      acc_cyc.delete();
      acc_ch.delete();
   endtask

   task automatic write_period(input int ch, input int per);
      cfg_we     = 1'b1;
      cfg_ch     = 2'(ch);
      cfg_period = PER_W'(per);
      step();
      cfg_we     = 1'b0;
   endtask

   initial begin
      int oc;
      model_reset();

      // Reset state and single-channel default rate
      do_reset();
      check_eq("rst_valid", upd_valid, 0);
      check_eq("rst_ch", upd_ch, 0);
      check_eq("rst_pend", pend, 0);
      ch_en     = 4'b0001;
      upd_ready = 1'b1;
      run(35);
      check_eq("ch0_first_offer", rise_at(0), 11);
      check_eq("ch0_interval", rise_at(1) - rise_at(0), 10);
      check_eq("ch0_interval2", rise_at(2) - rise_at(1), 10);

      // All channels backed up, then drained in round-robin order
      do_reset();
      ch_en = 4'b1111;
      run(30);
      upd_ready = 1'b1;
      run(12);
      for (int k = 0; k < 4; k++) check_eq($sformatf("rr_order%0d", k), acc_ch_at(k), k);
      check_eq("rr_first_accept", acc_cyc_at(0), 31);
      for (int k = 1; k < 4; k++)
         check_eq($sformatf("rr_gap%0d", k), acc_cyc_at(k) - acc_cyc_at(k-1), 2);
`ifdef MOVE_SCHED_MISS_CNT_EN
      for (int i = 0; i < NUM_CH; i++) check_eq($sformatf("rr_miss%0d", i), miss_cnt[8*i +: 8], 2);
`endif

      // Programmed period 4, then clamped period 1 -> 2
      do_reset();
      ch_en     = 4'b0100;
      upd_ready = 1'b1;
      write_period(2, 4);
      run(24);
      check_eq("p4_first", rise_at(0), 6);
      check_eq("p4_interval", rise_at(1) - rise_at(0), 4);
      write_period(2, 1);
      rise_q.delete();
      run(16);
      check_eq("p1_interval", rise_at(2) - rise_at(1), 2);
      check_eq("p1_interval2", rise_at(3) - rise_at(2), 2);

      // Stalled offer stays stable, even when its channel is disabled
      upd_ready = 1'b0;
      for (int k = 0; k < 10 && upd_valid !== 1'b1; k++) step();
      check_eq("stall_valid_seen", upd_valid, 1);
      oc    = int'(upd_ch);
      ch_en = '0;
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("stall_valid", upd_valid, 1);
         check_eq("stall_ch", upd_ch, oc);
      end
      upd_ready = 1'b1;
      step();
      step();
      check_eq("stall_release", upd_valid, 0);

      // Expiry on ch1 coinciding with its handshake
      do_reset();
      ch_en     = 4'b0010;
      upd_ready = 1'b1;
      write_period(1, 2);
      run(20);
      check_eq("coinc_pend1", pend[1], 1);
`ifdef MOVE_SCHED_MISS_CNT_EN
      check_eq("coinc_miss1", miss_cnt[15:8], 0);
`endif

      // Reset during an offer
      do_reset();
      ch_en = 4'b1111;
      write_period(0, 3);
      for (int k = 0; k < 20 && upd_valid !== 1'b1; k++) step();
      check_eq("rst_offer_seen", upd_valid, 1);
      rst = 1'b1;
      step();
      check_eq("rst_offer_valid", upd_valid, 0);
      check_eq("rst_offer_pend", pend, 0);
      rst       = 1'b0;
      ch_en     = 4'b0001;
      upd_ready = 1'b1;
      cyc       = 0;
      rise_q.delete();
      run(15);
      check_eq("rst_period_restored", rise_at(0), 11);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rst        = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 49) == 0) ch_en = 4'($urandom_range(0, 15));
         upd_ready  = ($urandom_range(0, 3) != 0);
         cfg_we     = ($urandom_range(0, 19) == 0);
         cfg_ch     = 2'($urandom_range(0, 3));
         cfg_period = PER_W'($urandom_range(0, 12));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
